// File: rtl/axi4_lite_regfile_if.sv
// ============================================================================
// Module   : axi4_lite_regfile_if
// Brief    : AXI4-Lite channel bundle (no write strobes) for the register file.
// Revision : 1.0
// ============================================================================
`default_nettype none

interface axi4_lite_regfile_if #(
    parameter int DW = 32,
    parameter int AW = 32
);
    logic [AW-1:0] S_AXI_AWADDR;
    logic          S_AXI_AWVALID;
    logic          S_AXI_AWREADY;
    logic [DW-1:0] S_AXI_WDATA;
    logic          S_AXI_WVALID;
    logic          S_AXI_WREADY;
    logic [1:0]    S_AXI_BRESP;
    logic          S_AXI_BVALID;
    logic          S_AXI_BREADY;
    logic [AW-1:0] S_AXI_ARADDR;
    logic          S_AXI_ARVALID;
    logic          S_AXI_ARREADY;
    logic [DW-1:0] S_AXI_RDATA;
    logic [1:0]    S_AXI_RRESP;
    logic          S_AXI_RVALID;
    logic          S_AXI_RREADY;

    modport slave (
        input  S_AXI_AWADDR, S_AXI_AWVALID, output S_AXI_AWREADY,
        input  S_AXI_WDATA,  S_AXI_WVALID,  output S_AXI_WREADY,
        output S_AXI_BRESP,  S_AXI_BVALID,  input  S_AXI_BREADY,
        input  S_AXI_ARADDR, S_AXI_ARVALID, output S_AXI_ARREADY,
        output S_AXI_RDATA,  S_AXI_RRESP,   S_AXI_RVALID, input S_AXI_RREADY
    );

    modport master (
        output S_AXI_AWADDR, S_AXI_AWVALID, input  S_AXI_AWREADY,
        output S_AXI_WDATA,  S_AXI_WVALID,  input  S_AXI_WREADY,
        input  S_AXI_BRESP,  S_AXI_BVALID,  output S_AXI_BREADY,
        output S_AXI_ARADDR, S_AXI_ARVALID, input  S_AXI_ARREADY,
        input  S_AXI_RDATA,  S_AXI_RRESP,   S_AXI_RVALID, output S_AXI_RREADY
    );
endinterface

`default_nettype wire

// File: rtl/axi4_lite_regfile.sv
// ============================================================================
// Module   : axi4_lite_regfile
// Brief    : AXI4-Lite slave exposing NREG full-word registers, with independent
//            write and read state machines and per-register write strobes.
// Revision : 1.0
// ============================================================================
`default_nettype none

module axi4_lite_regfile #(
    parameter int DW   = 32,
    parameter int AW   = 32,
    parameter int NREG = 16
) (
    input  wire logic               clk,
    input  wire logic               resetn,
    axi4_lite_regfile_if.slave      s_axi,
    output logic [NREG*DW-1:0]      regs_out,
    output logic [NREG-1:0]         wr_strobe
);

    localparam int IW = $clog2(NREG);

    typedef enum logic [0:0] {W_COLLECT = 1'b0, W_RESP = 1'b1} wstate_t;
    typedef enum logic [0:0] {R_IDLE    = 1'b0, R_DATA = 1'b1} rstate_t;

    wstate_t         wstate;
    rstate_t         rstate;
    logic            aw_held, w_held, aw_oor;
    logic [IW-1:0]   aw_idx;
    logic [DW-1:0]   wdata_q;
    logic            awready, wready, bvalid, arready, rvalid;
    logic [1:0]      bresp, rresp;
    logic [DW-1:0]   rdata;

    logic            aw_fire, w_fire, ar_fire, commit;
    logic [IW-1:0]   new_aw_idx, ar_idx, cm_idx;
    logic            new_aw_oor, ar_oor, cm_oor;
    logic [DW-1:0]   cm_data;
    logic            unused_addr_bits;

    // Byte-lane bits never select anything; upper bits beyond the index mark out-of-range.
    assign new_aw_idx = s_axi.S_AXI_AWADDR[IW+1:2];
    assign new_aw_oor = |(s_axi.S_AXI_AWADDR >> (IW + 2));
    assign ar_idx     = s_axi.S_AXI_ARADDR[IW+1:2];
    assign ar_oor     = |(s_axi.S_AXI_ARADDR >> (IW + 2));
    assign unused_addr_bits = ^{s_axi.S_AXI_AWADDR[1:0], s_axi.S_AXI_ARADDR[1:0]};

    assign aw_fire = s_axi.S_AXI_AWVALID & awready;
    assign w_fire  = s_axi.S_AXI_WVALID  & wready;
    assign ar_fire = s_axi.S_AXI_ARVALID & arready;
    assign commit  = (wstate == W_COLLECT) && (aw_held || aw_fire) && (w_held || w_fire);
    assign cm_idx  = aw_held ? aw_idx  : new_aw_idx;
    assign cm_oor  = aw_held ? aw_oor  : new_aw_oor;
    assign cm_data = w_held  ? wdata_q : s_axi.S_AXI_WDATA;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            wstate  <= W_COLLECT;
            aw_held <= 1'b0;
            w_held  <= 1'b0;
            aw_idx  <= '0;
            aw_oor  <= 1'b0;
            wdata_q <= '0;
            awready <= 1'b0;
            wready  <= 1'b0;
            bvalid  <= 1'b0;
            bresp   <= 2'b00;
        end else begin
            case (wstate)
                W_COLLECT: begin
                    if (commit) begin
                        wstate  <= W_RESP;
                        aw_held <= 1'b0;
                        w_held  <= 1'b0;
                        awready <= 1'b0;
                        wready  <= 1'b0;
                        bvalid  <= 1'b1;
                        bresp   <= cm_oor ? 2'b10 : 2'b00;
                    end else begin
                        if (aw_fire) begin
                            aw_held <= 1'b1;
                            aw_idx  <= new_aw_idx;
                            aw_oor  <= new_aw_oor;
                        end
                        if (w_fire) begin
                            w_held  <= 1'b1;
                            wdata_q <= s_axi.S_AXI_WDATA;
                        end
                        // Readies come up here on the first edge out of reset as well.
                        awready <= !(aw_held || aw_fire);
                        wready  <= !(w_held || w_fire);
                    end
                end
                W_RESP: begin
                    if (s_axi.S_AXI_BREADY) begin
                        wstate  <= W_COLLECT;
                        bvalid  <= 1'b0;
                        bresp   <= 2'b00;
                        awready <= 1'b1;
                        wready  <= 1'b1;
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            regs_out  <= '0;
            wr_strobe <= '0;
        end else begin
            wr_strobe <= '0;
            if (commit && !cm_oor) begin
                regs_out[cm_idx*DW +: DW] <= cm_data;
                wr_strobe[cm_idx]         <= 1'b1;
            end
        end
    end

    // Reads sample regs_out before any write landing on the same edge.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            rstate  <= R_IDLE;
            arready <= 1'b0;
            rvalid  <= 1'b0;
            rresp   <= 2'b00;
            rdata   <= '0;
        end else begin
            case (rstate)
                R_IDLE: begin
                    if (ar_fire) begin
                        rstate  <= R_DATA;
                        arready <= 1'b0;
                        rvalid  <= 1'b1;
                        rresp   <= ar_oor ? 2'b10 : 2'b00;
                        rdata   <= ar_oor ? '0 : regs_out[ar_idx*DW +: DW];
                    end else begin
                        arready <= 1'b1;
                    end
                end
                R_DATA: begin
                    if (s_axi.S_AXI_RREADY) begin
                        rstate  <= R_IDLE;
                        arready <= 1'b1;
                        rvalid  <= 1'b0;
                    end
                end
            endcase
        end
    end

    assign s_axi.S_AXI_AWREADY = awready;
    assign s_axi.S_AXI_WREADY  = wready;
    assign s_axi.S_AXI_BVALID  = bvalid;
    assign s_axi.S_AXI_BRESP   = bresp;
    assign s_axi.S_AXI_ARREADY = arready;
    assign s_axi.S_AXI_RVALID  = rvalid;
    assign s_axi.S_AXI_RRESP   = rresp;
    assign s_axi.S_AXI_RDATA   = rdata;

endmodule

`default_nettype wire

// File: tb/tb_axi4_lite_regfile.sv
// ============================================================================
// Module   : tb_axi4_lite_regfile
// Brief    : Directed plus randomized bench for axi4_lite_regfile against an
//            array-based register model.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_axi4_lite_regfile;

    localparam int DW   = 32;
    localparam int AW   = 32;
    localparam int NREG = 16;

    logic                 clk = 1'b0;
    logic                 resetn = 1'b0;
    logic [NREG*DW-1:0]   regs_out;
    logic [NREG-1:0]      wr_strobe;

    int                   checks = 0;
    int                   errors = 0;
    logic [DW-1:0]        model [NREG];

    axi4_lite_regfile_if #(.DW(DW), .AW(AW)) bus ();

    axi4_lite_regfile #(.DW(DW), .AW(AW), .NREG(NREG)) dut (
        .clk       (clk),
        .resetn    (resetn),
        .s_axi     (bus.slave),
        .regs_out  (regs_out),
        .wr_strobe (wr_strobe)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [511:0] obs, input logic [511:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [NREG*DW-1:0] model_flat();
        logic [NREG*DW-1:0] v;
        for (int i = 0; i < NREG; i++) v[i*DW +: DW] = model[i];
        return v;
    endfunction

    function automatic bit addr_oor(input logic [AW-1:0] addr);
        return (addr >> 2) >= NREG;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // lead > 0: W leads AW by lead cycles; lead < 0: AW leads W.
    task automatic axi_write(input logic [AW-1:0] addr, input logic [DW-1:0] data,
                             input int lead, input int bdelay);
        bit            oor;
        logic [1:0]    exp_resp;
        logic [NREG-1:0] exp_strb;
        bit            aw_done, w_done, aw_fire, w_fire;
        int            aw_at, w_at, cyc;
        oor      = addr_oor(addr);
        exp_resp = oor ? 2'b10 : 2'b00;
        exp_strb = oor ? '0 : (NREG'(1) << (addr >> 2));
        aw_at    = (lead > 0) ? lead : 0;
        w_at     = (lead < 0) ? -lead : 0;
        aw_done  = 0;
        w_done   = 0;
        cyc      = 0;
        while (!(aw_done && w_done) && cyc < 20) begin
            if (cyc == aw_at) begin bus.S_AXI_AWADDR = addr; bus.S_AXI_AWVALID = 1'b1; end
            if (cyc == w_at)  begin bus.S_AXI_WDATA  = data; bus.S_AXI_WVALID  = 1'b1; end
            aw_fire = bus.S_AXI_AWVALID && bus.S_AXI_AWREADY;
            w_fire  = bus.S_AXI_WVALID  && bus.S_AXI_WREADY;
            tick();
            if (aw_fire) begin aw_done = 1; bus.S_AXI_AWVALID = 1'b0; end
            if (w_fire)  begin w_done  = 1; bus.S_AXI_WVALID  = 1'b0; end
            cyc++;
        end
        check("wr_handshake", {510'd0, aw_done, w_done}, 512'd3);
        if (!oor) model[addr >> 2] = data;
        check("bvalid_set", bus.S_AXI_BVALID, 1'b1);
        check("bresp", bus.S_AXI_BRESP, exp_resp);
        check("wr_strobe", wr_strobe, exp_strb);
        check("regs_after_wr", regs_out, model_flat());
        check("ready_in_resp", {bus.S_AXI_AWREADY, bus.S_AXI_WREADY}, 2'b00);
        repeat (bdelay) begin
            tick();
            check("bvalid_hold", {bus.S_AXI_BVALID, bus.S_AXI_BRESP}, {1'b1, exp_resp});
            check("ready_hold", {bus.S_AXI_AWREADY, bus.S_AXI_WREADY, wr_strobe}, '0);
        end
        bus.S_AXI_BREADY = 1'b1;
        tick();
        bus.S_AXI_BREADY = 1'b0;
        check("bvalid_clr", bus.S_AXI_BVALID, 1'b0);
        check("ready_back", {bus.S_AXI_AWREADY, bus.S_AXI_WREADY, wr_strobe}, {2'b11, NREG'(0)});
    endtask

    task automatic axi_read(input logic [AW-1:0] addr, input int rdelay);
        bit            oor, done, fire;
        logic [DW-1:0] exp_data;
        logic [1:0]    exp_resp;
        int            cyc;
        oor      = addr_oor(addr);
        exp_data = oor ? '0 : model[addr >> 2];
        exp_resp = oor ? 2'b10 : 2'b00;
        bus.S_AXI_ARADDR  = addr;
        bus.S_AXI_ARVALID = 1'b1;
        done = 0;
        cyc  = 0;
        while (!done && cyc < 20) begin
            fire = bus.S_AXI_ARVALID && bus.S_AXI_ARREADY;
            tick();
            if (fire) begin done = 1; bus.S_AXI_ARVALID = 1'b0; end
            cyc++;
        end
        check("rd_handshake", done, 1'b1);
        check("rvalid_set", {bus.S_AXI_RVALID, bus.S_AXI_ARREADY}, 2'b10);
        check("rdata", bus.S_AXI_RDATA, exp_data);
        check("rresp", bus.S_AXI_RRESP, exp_resp);
        repeat (rdelay) begin
            tick();
            check("rvalid_hold", {bus.S_AXI_RVALID, bus.S_AXI_ARREADY, bus.S_AXI_RRESP, bus.S_AXI_RDATA},
                  {2'b10, exp_resp, exp_data});
        end
        bus.S_AXI_RREADY = 1'b1;
        tick();
        bus.S_AXI_RREADY = 1'b0;
        check("rvalid_clr", {bus.S_AXI_RVALID, bus.S_AXI_ARREADY}, 2'b01);
    endtask

    initial begin
        logic [AW-1:0] addr;
        logic [DW-1:0] old_val;
        for (int i = 0; i < NREG; i++) model[i] = '0;
        bus.S_AXI_AWADDR = '0; bus.S_AXI_AWVALID = 1'b0;
        bus.S_AXI_WDATA  = '0; bus.S_AXI_WVALID  = 1'b0;
        bus.S_AXI_BREADY = 1'b0;
        bus.S_AXI_ARADDR = '0; bus.S_AXI_ARVALID = 1'b0;
        bus.S_AXI_RREADY = 1'b0;

        // Reset state and release timing
        repeat (3) tick();
        check("rst_ready", {bus.S_AXI_AWREADY, bus.S_AXI_WREADY, bus.S_AXI_ARREADY}, 3'b000);
        check("rst_valid", {bus.S_AXI_BVALID, bus.S_AXI_RVALID, bus.S_AXI_BRESP, bus.S_AXI_RRESP}, '0);
        check("rst_rdata", bus.S_AXI_RDATA, '0);
        check("rst_regs", {wr_strobe, regs_out}, '0);
        resetn = 1'b1;
        #2;
        check("rel_ready_low", {bus.S_AXI_AWREADY, bus.S_AXI_WREADY, bus.S_AXI_ARREADY}, 3'b000);
        tick();
        check("rel_ready_high", {bus.S_AXI_AWREADY, bus.S_AXI_WREADY, bus.S_AXI_ARREADY}, 3'b111);

        // Same-cycle write, immediate BREADY
        axi_write(32'h08, 32'hDEADBEEF, 0, 0);
        // W three cycles ahead of AW, BREADY held off for four cycles
        axi_write(32'h3C, 32'h12345678, 3, 4);
        // AW ahead of W
        axi_write(32'h14, 32'h0BADF00D, -2, 1);
        // Read with RREADY held off
        axi_read(32'h08, 3);
        axi_read(32'h3C, 0);
        // Out-of-range write and read
        axi_write(32'h40, 32'hFFFFFFFF, 0, 0);
        axi_read(32'h1000, 1);

        // Same-edge read and write of register 1
        old_val = model[1];
        bus.S_AXI_AWADDR = 32'h04; bus.S_AXI_AWVALID = 1'b1;
        bus.S_AXI_WDATA  = 32'hA5A5A5A5; bus.S_AXI_WVALID = 1'b1;
        bus.S_AXI_ARADDR = 32'h04; bus.S_AXI_ARVALID = 1'b1;
        tick();
        bus.S_AXI_AWVALID = 1'b0; bus.S_AXI_WVALID = 1'b0; bus.S_AXI_ARVALID = 1'b0;
        model[1] = 32'hA5A5A5A5;
        check("same_edge_old", bus.S_AXI_RDATA, old_val);
        check("same_edge_valid", {bus.S_AXI_BVALID, bus.S_AXI_RVALID}, 2'b11);
        check("same_edge_regs", regs_out, model_flat());
        bus.S_AXI_BREADY = 1'b1; bus.S_AXI_RREADY = 1'b1;
        tick();
        bus.S_AXI_BREADY = 1'b0; bus.S_AXI_RREADY = 1'b0;
        check("same_edge_clr", {bus.S_AXI_BVALID, bus.S_AXI_RVALID}, 2'b00);
        axi_read(32'h04, 0);

        // Randomized traffic
        for (int n = 0; n < 40; n++) begin
            if ($urandom_range(0, 7) == 0)
                addr = (AW'($urandom_range(1, 1023)) << 6) | AW'($urandom_range(0, 63));
            else
                addr = (AW'($urandom_range(0, NREG-1)) << 2) | AW'($urandom_range(0, 3));
            if ($urandom_range(0, 1) == 1)
                axi_write(addr, $urandom, int'($urandom_range(0, 6)) - 3, int'($urandom_range(0, 2)));
            else
                axi_read(addr, int'($urandom_range(0, 2)));
        end

        // Reset in the middle of a write with only the address accepted
        bus.S_AXI_AWADDR = 32'h10; bus.S_AXI_AWVALID = 1'b1;
        tick();
        bus.S_AXI_AWVALID = 1'b0;
        resetn = 1'b0;
        #1;
        for (int i = 0; i < NREG; i++) model[i] = '0;
        check("mid_rst_ready", {bus.S_AXI_AWREADY, bus.S_AXI_WREADY, bus.S_AXI_ARREADY}, 3'b000);
        check("mid_rst_out", {bus.S_AXI_BVALID, bus.S_AXI_RVALID, bus.S_AXI_BRESP, bus.S_AXI_RRESP,
                              bus.S_AXI_RDATA}, '0);
        check("mid_rst_regs", {wr_strobe, regs_out}, '0);
        tick();
        resetn = 1'b1;
        #2;
        check("mid_rel_low", {bus.S_AXI_AWREADY, bus.S_AXI_WREADY, bus.S_AXI_ARREADY}, 3'b000);
        tick();
        check("mid_rel_high", {bus.S_AXI_AWREADY, bus.S_AXI_WREADY, bus.S_AXI_ARREADY}, 3'b111);
        // A lone W must not pair with the address discarded by reset
        bus.S_AXI_WDATA = 32'hCAFEF00D; bus.S_AXI_WVALID = 1'b1;
        tick();
        bus.S_AXI_WVALID = 1'b0;
        tick();
        check("no_stale_commit", {bus.S_AXI_BVALID, wr_strobe}, '0);
        check("no_stale_regs", regs_out, model_flat());
        bus.S_AXI_AWADDR = 32'h10; bus.S_AXI_AWVALID = 1'b1;
        tick();
        bus.S_AXI_AWVALID = 1'b0;
        model[4] = 32'hCAFEF00D;
        check("late_aw_commit", {bus.S_AXI_BVALID, wr_strobe}, {1'b1, NREG'(16)});
        check("late_aw_regs", regs_out, model_flat());
        bus.S_AXI_BREADY = 1'b1;
        tick();
        bus.S_AXI_BREADY = 1'b0;
        axi_read(32'h10, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire
